// File: rtl/alu_arb_pkg.sv
// alu_arb_pkg: shared states and constants for the ALU arbiter
package alu_arb_pkg;
  typedef enum logic [1:0] {IDLE, EXEC, RESP} alu_arb_state_t;
  localparam logic ALU_OP_ADD = 1'b1;
  localparam int ALU_W = 8;
endpackage

// File: rtl/alu.sv
// alu: W-bit add/subtract unit; op=1 adds, op=0 computes a-b as a+~b+1
module alu
  import alu_arb_pkg::*;
#(
  parameter int W = ALU_W
) (
  input  logic         op,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] result,
  output logic         cf,
  output logic         ovf
);
  logic [W-1:0] bb;
  assign bb = (op == ALU_OP_ADD) ? b : ~b;
  assign {cf, result} = {1'b0, a} + {1'b0, bb} + {{W{1'b0}}, op != ALU_OP_ADD};
  assign ovf = (a[W-1] == bb[W-1]) && (result[W-1] != a[W-1]);
endmodule

// File: rtl/alu_arb_rr.sv
// alu_arb_rr: 2-way one-hot grant; round-robin by default, fixed priority under ALU_ARB_FIXED_PRIO_EN
module alu_arb_rr (
  input  logic [1:0] req_valid,
  input  logic       last_grant,
  input  logic       en,
  output logic [1:0] grant
);
`ifdef ALU_ARB_FIXED_PRIO_EN
  assign grant = !en ? 2'b00 : req_valid[0] ? 2'b01 : {req_valid[1], 1'b0};
`else
  assign grant = !en ? 2'b00 : (&req_valid) ? (last_grant ? 2'b01 : 2'b10) : req_valid;
`endif
endmodule

// File: rtl/alu_arbiter.sv
// alu_arbiter: shares one ALU between two valid/ready requesters (ALU_ARB_FIXED_PRIO_EN: fixed priority)
module alu_arbiter
  import alu_arb_pkg::*;
#(
  parameter int NREQ = 2,
  parameter int W = ALU_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NREQ-1:0]   req_valid,
  output logic [NREQ-1:0]   req_ready,
  input  logic [NREQ-1:0]   req_op,
  input  logic [NREQ*W-1:0] req_a,
  input  logic [NREQ*W-1:0] req_b,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic              rsp_id,
  output logic [W-1:0]      rsp_result,
  output logic              rsp_cf,
  output logic              rsp_ovf
);
  alu_arb_state_t state, state_n;
  logic [NREQ-1:0] grant;
  logic hs, gid, last_grant, op_q, id_q, alu_cf, alu_ovf;
  logic [W-1:0] a_q, b_q, alu_res;

  alu_arb_rr u_rr (
    .req_valid (req_valid),
    .last_grant(last_grant),
    .en        (state == IDLE && rst_n),
    .grant     (grant)
  );

  alu #(.W(W)) u_alu (
    .op    (op_q),
    .a     (a_q),
    .b     (b_q),
    .result(alu_res),
    .cf    (alu_cf),
    .ovf   (alu_ovf)
  );

  assign req_ready = grant;
  assign hs = |grant;
  assign gid = grant[1];
  assign rsp_valid = (state == RESP) && rst_n;

  // next state: accept in IDLE, one execute cycle, hold response until taken
  always_comb begin
    state_n = state == IDLE ? (hs ? EXEC : IDLE) : state == EXEC ? RESP : (rsp_ready ? IDLE : RESP);
  end

  // state, operand latch at handshake, result capture at end of EXEC
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      last_grant <= 1'b1;
      op_q       <= 1'b0;
      id_q       <= 1'b0;
      a_q        <= '0;
      b_q        <= '0;
      rsp_id     <= 1'b0;
      rsp_result <= '0;
      rsp_cf     <= 1'b0;
      rsp_ovf    <= 1'b0;
    end else begin
      state <= state_n;
      if (hs) begin
        last_grant <= gid;
        id_q       <= gid;
        op_q       <= req_op[gid];
        a_q        <= gid ? req_a[2*W-1:W] : req_a[W-1:0];
        b_q        <= gid ? req_b[2*W-1:W] : req_b[W-1:0];
      end
      if (state == EXEC) begin
        rsp_id     <= id_q;
        rsp_result <= alu_res;
        rsp_cf     <= alu_cf;
        rsp_ovf    <= alu_ovf;
      end
    end
  end
endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: directed table-driven bench for alu_arbiter
module tb_alu_arbiter;
  logic clk = 1'b0;
  logic rst_n;
  logic [1:0] req_valid, req_ready, req_op;
  logic [15:0] req_a, req_b;
  logic rsp_valid, rsp_ready, rsp_id, rsp_cf, rsp_ovf;
  logic [7:0] rsp_result;
  int cyc = 0;
  int n_chk = 0;
  int n_fail = 0;
  int rid[3], rres[3], rcyc[3];
  int nres;

  typedef struct {
    int id;
    logic op;
    logic [7:0] a, b, res;
    logic cf, ovf;
  } vec_t;
  vec_t vt[8];

  alu_arbiter dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_op    (req_op),
    .req_a     (req_a),
    .req_b     (req_b),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_id    (rsp_id),
    .rsp_result(rsp_result),
    .rsp_cf    (rsp_cf),
    .rsp_ovf   (rsp_ovf)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", n, act, exp);
    end
  endtask

  task automatic drive(input int id, input logic op, input logic [7:0] a, input logic [7:0] b);
    req_op[id] = op;
    if (id == 0) begin
      req_a[7:0] = a;
      req_b[7:0] = b;
    end else begin
      req_a[15:8] = a;
      req_b[15:8] = b;
    end
    req_valid[id] = 1'b1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // full transaction from a negedge in IDLE; returns at a negedge back in IDLE
  task automatic xact(input int id, input logic op, input logic [7:0] a, input logic [7:0] b,
                      input logic [7:0] er, input logic ecf, input logic eovf);
    int t0;
    drive(id, op, a, b);
    #1;
    for (int i = 0; i < 20 && !req_ready[id]; i++) begin
      @(negedge clk);
      #1;
    end
    chk("grant", {30'd0, req_ready}, (id == 0) ? 32'd1 : 32'd2);
    t0 = cyc;
    @(negedge clk);
    req_valid[id] = 1'b0;
    req_a = 16'hA5A5;
    req_b = 16'h5A5A;
    #1;
    chk("exec_no_rsp", {31'd0, rsp_valid}, 32'd0);
    @(negedge clk);
    #1;
    chk("rsp_valid", {31'd0, rsp_valid}, 32'd1);
    chk("latency", cyc - t0, 32'd2);
    chk("rsp_id", {31'd0, rsp_id}, id);
    chk("rsp_result", {24'd0, rsp_result}, {24'd0, er});
    chk("rsp_cf", {31'd0, rsp_cf}, {31'd0, ecf});
    chk("rsp_ovf", {31'd0, rsp_ovf}, {31'd0, eovf});
    @(negedge clk);
    #1;
    chk("rsp_one_cycle", {31'd0, rsp_valid}, 32'd0);
  endtask

  task automatic collect();
    nres = 0;
    for (int i = 0; i < 40 && nres < 3; i++) begin
      #1;
      if (rsp_valid) begin
        rid[nres] = rsp_id;
        rres[nres] = rsp_result;
        rcyc[nres] = cyc;
        nres++;
      end
      @(negedge clk);
    end
    chk("collect_count", nres, 32'd3);
  endtask

  initial begin
    int t0;
    vt[0] = '{0, 1'b1, 8'd5,   8'd43,  8'd48,  1'b0, 1'b0};
    vt[1] = '{1, 1'b1, 8'h80,  8'h80,  8'h00,  1'b1, 1'b1};
    vt[2] = '{0, 1'b1, 8'h7F,  8'h01,  8'h80,  1'b0, 1'b1};
    vt[3] = '{1, 1'b1, 8'hFF,  8'h01,  8'h00,  1'b1, 1'b0};
    vt[4] = '{0, 1'b1, 8'd100, 8'd27,  8'd127, 1'b0, 1'b0};
    vt[5] = '{0, 1'b0, 8'h10,  8'h03,  8'h0D,  1'b1, 1'b0};
    vt[6] = '{1, 1'b0, 8'h03,  8'h05,  8'hFE,  1'b0, 1'b0};
    vt[7] = '{0, 1'b0, 8'h80,  8'h01,  8'h7F,  1'b1, 1'b1};
    req_valid = 2'b00;
    req_op = 2'b00;
    req_a = '0;
    req_b = '0;
    rsp_ready = 1'b1;
    rst_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    req_valid = 2'b11;
    #1;
    chk("rst_req_ready", {30'd0, req_ready}, 32'd0);
    chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    chk("rst_outputs", {20'd0, rsp_id, rsp_result, rsp_cf, rsp_ovf}, 32'd0);
    req_valid = 2'b00;
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) xact(vt[i].id, vt[i].op, vt[i].a, vt[i].b, vt[i].res, vt[i].cf, vt[i].ovf);

    // tie after reset: both continuously valid
    do_reset();
    drive(0, 1'b1, 8'd1, 8'd1);
    drive(1, 1'b1, 8'd2, 8'd2);
    collect();
    req_valid = 2'b00;
`ifdef ALU_ARB_FIXED_PRIO_EN
    chk("tie_id1", rid[1], 32'd0);
    chk("tie_res1", rres[1], 32'd2);
`else
    chk("tie_id1", rid[1], 32'd1);
    chk("tie_res1", rres[1], 32'd4);
`endif
    chk("tie_id0", rid[0], 32'd0);
    chk("tie_res0", rres[0], 32'd2);
    chk("tie_id2", rid[2], 32'd0);
    chk("tie_res2", rres[2], 32'd2);

    // throughput: requester 0 alone, always valid
    do_reset();
    drive(0, 1'b1, 8'd3, 8'd4);
    collect();
    req_valid = 2'b00;
    chk("thru_gap1", rcyc[1] - rcyc[0], 32'd3);
    chk("thru_gap2", rcyc[2] - rcyc[1], 32'd3);
    chk("thru_res", rres[2], 32'd7);
    chk("thru_id", rid[1], 32'd0);

    // backpressure with a pending request from requester 1
    do_reset();
    @(negedge clk);
    rsp_ready = 1'b0;
    drive(0, 1'b1, 8'd10, 8'd20);
    #1;
    chk("bp_grant", {30'd0, req_ready}, 32'd1);
    @(negedge clk);
    req_valid[0] = 1'b0;
    @(negedge clk);
    drive(1, 1'b1, 8'd1, 8'd2);
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("bp_valid", {31'd0, rsp_valid}, 32'd1);
      chk("bp_hold", {22'd0, rsp_id, rsp_result, rsp_cf}, {22'd0, 1'b0, 8'd30, 1'b0});
      chk("bp_req_ready", {30'd0, req_ready}, 32'd0);
      @(negedge clk);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    #1;
    chk("bp_next_accept", {30'd0, req_ready}, 32'd2);
    chk("bp_rsp_done", {31'd0, rsp_valid}, 32'd0);
    t0 = cyc;
    @(negedge clk);
    req_valid[1] = 1'b0;
    @(negedge clk);
    #1;
    chk("bp2_valid", {31'd0, rsp_valid}, 32'd1);
    chk("bp2_latency", cyc - t0, 32'd2);
    chk("bp2_result", {23'd0, rsp_id, rsp_result}, {23'd0, 1'b1, 8'd3});
    @(negedge clk);

    // reset asserted during EXEC abandons the transaction
    drive(0, 1'b1, 8'd100, 8'd100);
    #1;
    chk("mid_grant", {30'd0, req_ready}, 32'd1);
    @(negedge clk);
    req_valid[0] = 1'b0;
    rst_n = 1'b0;
    @(negedge clk);
    #1;
    chk("mid_rst_valid", {31'd0, rsp_valid}, 32'd0);
    chk("mid_rst_outputs", {20'd0, rsp_id, rsp_result, rsp_cf, rsp_ovf}, 32'd0);
    chk("mid_rst_ready", {30'd0, req_ready}, 32'd0);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      #1;
      chk("mid_no_rsp", {31'd0, rsp_valid}, 32'd0);
    end
    @(negedge clk);
    xact(0, 1'b1, 8'd100, 8'd100, 8'd200, 1'b0, 1'b1);
    xact(1, 1'b1, 8'd250, 8'd10, 8'd4, 1'b1, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end
endmodule
